// File: rtl/gam_learning_sequencer_pkg.sv
// Shared types and sizes for the GAM learning sequencer and its pattern store.
package gam_learning_sequencer_pkg;

  localparam int unsigned CLASS_COUNT   = 4;
  localparam int unsigned NODE_COUNT    = 8;
  localparam int unsigned NODE_VECTOR_W = 32;
  localparam int unsigned CLASS_W       = $clog2(CLASS_COUNT);
  localparam int unsigned NODE_W        = $clog2(NODE_COUNT);
  localparam int unsigned CNT_W         = $clog2(NODE_COUNT + 1);

  typedef logic [NODE_VECTOR_W-1:0] node_vector_T;

  typedef enum logic {LEARNING = 1'b0, RECALL = 1'b1} LEARNING_RECALL_T;
  typedef enum logic {READY = 1'b0, WAIT = 1'b1} READY_WAIT_T;

  typedef enum logic [2:0] {IDLE, LOAD, PRESENT, BUSY, DONE, ERROR} SEQ_STATE_T;

  typedef logic [CLASS_COUNT-1:0][CNT_W-1:0] cnt_vec_t;

  typedef struct packed {
    logic [CLASS_W-1:0] cls;
    logic [NODE_W-1:0]  node;
  } seq_ptr_t;

  typedef struct packed {
    logic               found;
    logic [CLASS_W-1:0] cls;
  } class_sel_t;

  // Lowest non-empty class at index lo or above.
  function automatic class_sel_t find_class(input cnt_vec_t cnt, input int lo);
    class_sel_t sel;
    sel = '0;
    for (int k = 0; k < CLASS_COUNT; k++) begin
      if (!sel.found && k >= lo && cnt[k] != '0) begin
        sel.found = 1'b1;
        sel.cls   = CLASS_W'(k);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/gam_pattern_store.sv
// Append-only per-class pattern store with a registered read port.
module gam_pattern_store
  import gam_learning_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         wr_en_i,
  input  logic [CLASS_W-1:0] wr_class_i,
  input  node_vector_T wr_data_i,
  output logic         wr_full_o,
  output cnt_vec_t     cnt_o,
  input  logic         rd_en_i,
  input  seq_ptr_t     rd_ptr_i,
  output node_vector_T rd_data_o
);

  node_vector_T      store_q [CLASS_COUNT][NODE_COUNT];
  cnt_vec_t          cnt_q;
  node_vector_T      rd_data_q;
  logic [NODE_W-1:0] wr_idx;
  logic              wr_ok;

  assign wr_full_o = (cnt_q[wr_class_i] == CNT_W'(NODE_COUNT));
  assign wr_idx    = NODE_W'(cnt_q[wr_class_i]);
  assign wr_ok     = wr_en_i && !wr_full_o && !clear_i;
  assign cnt_o     = cnt_q;
  assign rd_data_o = rd_data_q;

  // Data array carries no reset; only slots below cnt are ever read.
  always_ff @(posedge clk) begin
    if (wr_ok) store_q[wr_class_i][wr_idx] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      if (clear_i)    cnt_q             <= '0;
      else if (wr_ok) cnt_q[wr_class_i] <= cnt_q[wr_class_i] + CNT_W'(1);
      if (rd_en_i)    rd_data_q         <= store_q[rd_ptr_i.cls][rd_ptr_i.node];
    end
  end

endmodule

// File: rtl/gam_learning_sequencer.sv
// Walks the pattern store class by class, handing each vector to Memory_Layer
// under the ready_wait handshake, then switches the layer to recall.
module gam_learning_sequencer
  import gam_learning_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [CLASS_W-1:0] wr_class,
  input  node_vector_T       wr_data,
  output logic               wr_full,
  input  logic               start,
  input  READY_WAIT_T        ready_wait,
  output node_vector_T       x,
  output logic [31:0]        c,
  output logic               learning_done,
  output LEARNING_RECALL_T   learning_recall,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  SEQ_STATE_T       state_q, state_d;
  seq_ptr_t         ptr_q, ptr_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [31:0]      c_q;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             terr_q;
  LEARNING_RECALL_T recall_q;

  cnt_vec_t   cnt, cnt_eff;
  logic       wr_accept, more_nodes, timed_out;
  class_sel_t first_sel, next_sel, tail_sel;

  assign wr_accept = wr_en && !clear && !wr_full && (state_q == IDLE || state_q == DONE);

  gam_pattern_store u_store (
    .clk        (clk),
    .rst_n      (reset),
    .clear_i    (clear),
    .wr_en_i    (wr_accept),
    .wr_class_i (wr_class),
    .wr_data_i  (wr_data),
    .wr_full_o  (wr_full),
    .cnt_o      (cnt),
    .rd_en_i    (state_q == LOAD),
    .rd_ptr_i   (ptr_q),
    .rd_data_o  (x)
  );

  // Counts as they will be after this cycle's write, so a write alongside start joins the pass.
  always_comb begin
    for (int k = 0; k < CLASS_COUNT; k++)
      cnt_eff[k] = cnt[k] + CNT_W'(wr_accept && (wr_class == CLASS_W'(k)));
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    first_sel  = find_class(cnt_eff, 0);
    next_sel   = find_class(cnt_eff, int'(ptr_q.cls) + 1);
    more_nodes = (CNT_W'(ptr_q.node) + CNT_W'(1)) < cnt_eff[ptr_q.cls];
    timed_out  = (to_q == TO_W'(TIMEOUT - 1));
    case (state_q)
      IDLE, DONE: begin
        if (start && first_sel.found) begin
          state_d = LOAD;
          ptr_d   = '{cls: first_sel.cls, node: '0};
        end
      end
      LOAD: state_d = PRESENT;
      PRESENT: begin
        if (ready_wait == WAIT) state_d = BUSY;
        else if (timed_out)     state_d = ERROR;
      end
      BUSY: begin
        if (ready_wait == READY) begin
          if (more_nodes) begin
            state_d    = LOAD;
            ptr_d.node = ptr_q.node + NODE_W'(1);
          end else if (next_sel.found) begin
            state_d = LOAD;
            ptr_d   = '{cls: next_sel.cls, node: '0};
          end else begin
            state_d = DONE;
          end
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;

    if (state_d != state_q)                         to_d = '0;
    else if (state_q == PRESENT || state_q == BUSY) to_d = to_q + TO_W'(1);
    else                                            to_d = to_q;

    tail_sel = find_class(cnt_eff, int'(ptr_d.cls) + 1);
    busy_d   = state_d inside {LOAD, PRESENT, BUSY};
    done_d   = busy_d && !tail_sel.found &&
               ((CNT_W'(ptr_d.node) + CNT_W'(1)) == cnt_eff[ptr_d.cls]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      to_q     <= '0;
      c_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      recall_q <= LEARNING;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      to_q     <= to_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      recall_q <= (state_d == DONE) ? RECALL : LEARNING;
      if (state_q == LOAD) c_q <= 32'(ptr_q.cls) + 32'd1;
      if (clear)                   terr_q <= 1'b0;
      else if (state_d == ERROR)   terr_q <= 1'b1;
    end
  end

  assign c               = c_q;
  assign learning_done   = done_q;
  assign learning_recall = recall_q;
  assign busy            = busy_q;
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_gam_learning_sequencer.sv
// Bench for gam_learning_sequencer: a per-class store model feeds an expected-pattern queue
// that a Memory_Layer handshake model pops and compares against x/c/learning_done.
module tb_gam_learning_sequencer;
  import gam_learning_sequencer_pkg::*;

  logic               clk;
  logic               reset;
  logic               clear;
  logic               wr_en;
  logic [CLASS_W-1:0] wr_class;
  node_vector_T       wr_data;
  logic               wr_full;
  logic               start;
  READY_WAIT_T        ready_wait;
  node_vector_T       x;
  logic [31:0]        c;
  logic               learning_done;
  LEARNING_RECALL_T   learning_recall;
  logic               busy;
  logic               timeout_err;

  typedef struct {
    node_vector_T x;
    logic [31:0]  c;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  node_vector_T mdl_data [CLASS_COUNT][NODE_COUNT];
  int           mdl_cnt  [CLASS_COUNT];
  node_vector_T hold_x;
  logic [31:0]  hold_c;
  int           n_cmp;
  int           n_err;

  gam_learning_sequencer #(.TIMEOUT(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .clear           (clear),
    .wr_en           (wr_en),
    .wr_class        (wr_class),
    .wr_data         (wr_data),
    .wr_full         (wr_full),
    .start           (start),
    .ready_wait      (ready_wait),
    .x               (x),
    .c               (c),
    .learning_done   (learning_done),
    .learning_recall (learning_recall),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int k = 0; k < CLASS_COUNT; k++) mdl_cnt[k] = 0;
  endtask

  task automatic model_append(input int cls, input node_vector_T d);
    if (mdl_cnt[cls] < NODE_COUNT) begin
      mdl_data[cls][mdl_cnt[cls]] = d;
      mdl_cnt[cls]++;
    end
  endtask

  task automatic build_expected();
    int total;
    int idx;
    exp_t e;
    total = 0;
    idx   = 0;
    for (int k = 0; k < CLASS_COUNT; k++) total += mdl_cnt[k];
    for (int k = 0; k < CLASS_COUNT; k++) begin
      for (int n = 0; n < mdl_cnt[k]; n++) begin
        e.x    = mdl_data[k][n];
        e.c    = 32'(k + 1);
        e.last = (idx == total - 1);
        exp_q.push_back(e);
        idx++;
      end
    end
  endtask

  task automatic write_vec(input int cls, input node_vector_T d);
    wr_en    = 1'b1;
    wr_class = CLASS_W'(cls);
    wr_data  = d;
    model_append(cls, d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
  endtask

  // Starts a pass (optionally with a same-cycle write) and acts as Memory_Layer for it.
  task automatic run_pass(input bit pace, input bit do_wr, input int wcls, input node_vector_T wdata);
    exp_t e;
    int   hold;
    if (do_wr) begin
      wr_en    = 1'b1;
      wr_class = CLASS_W'(wcls);
      wr_data  = wdata;
      model_append(wcls, wdata);
    end
    build_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (busy !== 1'b1 || learning_done !== e.last || x !== hold_x) begin
        n_err++;
        $display("FAIL load: busy=%b done=%b x=%h, expected busy=1 done=%b x=%h",
                 busy, learning_done, x, e.last, hold_x);
      end
      ready_wait = ($urandom_range(0, 1) != 0) ? WAIT : READY;
      @(negedge clk);
      hold = pace ? int'($urandom_range(0, 3)) : 0;
      ready_wait = READY;
      repeat (hold) @(negedge clk);
      n_cmp++;
      if (x !== e.x || c !== e.c) begin
        n_err++;
        $display("FAIL present_xc: x=%h c=%0d, expected x=%h c=%0d", x, c, e.x, e.c);
      end
      n_cmp++;
      if (learning_done !== e.last || busy !== 1'b1 || learning_recall !== LEARNING) begin
        n_err++;
        $display("FAIL present_flags: done=%b busy=%b recall=%b, expected done=%b busy=1 recall=0",
                 learning_done, busy, learning_recall, e.last);
      end
      hold_x = e.x;
      hold_c = e.c;
      ready_wait = WAIT;
      @(negedge clk);
      hold = pace ? int'($urandom_range(0, 3)) : 0;
      repeat (hold) @(negedge clk);
      n_cmp++;
      if (x !== e.x || c !== e.c || busy !== 1'b1 || learning_done !== e.last) begin
        n_err++;
        $display("FAIL busy_hold: x=%h c=%0d busy=%b done=%b, expected x=%h c=%0d busy=1 done=%b",
                 x, c, busy, learning_done, e.x, e.c, e.last);
      end
      ready_wait = READY;
      @(negedge clk);
    end
    n_cmp++;
    if (learning_recall !== RECALL || busy !== 1'b0 || learning_done !== 1'b0) begin
      n_err++;
      $display("FAIL done_flags: recall=%b busy=%b done=%b, expected recall=1 busy=0 done=0",
               learning_recall, busy, learning_done);
    end
    n_cmp++;
    if (x !== hold_x || c !== hold_c) begin
      n_err++;
      $display("FAIL done_hold: x=%h c=%0d, expected x=%h c=%0d", x, c, hold_x, hold_c);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (x !== '0 || c !== '0 || learning_done !== 1'b0 || learning_recall !== LEARNING ||
        busy !== 1'b0 || timeout_err !== 1'b0 || wr_full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: x=%h c=%0d done=%b recall=%b busy=%b terr=%b full=%b, expected all 0",
               x, c, learning_done, learning_recall, busy, timeout_err, wr_full);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || x !== '0) begin
      n_err++;
      $display("FAIL after_reset: busy=%b x=%h, expected busy=0 x=0", busy, x);
    end
  endtask

  task automatic test_one_class();
    write_vec(0, 32'h0000_0003);
    write_vec(0, 32'h0000_0400);
    write_vec(0, 32'h0007_0005);
    run_pass(1'b0, 1'b0, 0, '0);
    do_clear();
  endtask

  task automatic test_skip_and_back_to_back();
    write_vec(0, 32'h11);
    write_vec(0, 32'h12);
    write_vec(2, 32'h31);
    write_vec(2, 32'h32);
    run_pass(1'b1, 1'b0, 0, '0);
    run_pass(1'b1, 1'b0, 0, '0);
    do_clear();
  endtask

  task automatic test_full();
    for (int i = 0; i <= NODE_COUNT; i++) begin
      wr_class = CLASS_W'(3);
      #1;
      n_cmp++;
      if (wr_full !== (mdl_cnt[3] == NODE_COUNT)) begin
        n_err++;
        $display("FAIL wr_full_%0d: got %b, expected %b", i, wr_full, mdl_cnt[3] == NODE_COUNT);
      end
      write_vec(3, 32'hF000_0000 + 32'(i));
    end
    run_pass(1'b1, 1'b0, 0, '0);
    do_clear();
  endtask

  task automatic test_timeout();
    write_vec(1, 32'h0000_0ABC);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ready_wait = READY;
    @(negedge clk);
    repeat (63) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: busy=%b terr=%b, expected busy=1 terr=0", busy, timeout_err);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || learning_done !== 1'b0 || learning_recall !== LEARNING) begin
      n_err++;
      $display("FAIL timeout_err: busy=%b terr=%b done=%b recall=%b, expected busy=0 terr=1 done=0 recall=0",
               busy, timeout_err, learning_done, learning_recall);
    end
    hold_x = 32'h0000_0ABC;
    hold_c = 32'd2;
    ready_wait = WAIT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL error_sticky: busy=%b terr=%b, expected busy=0 terr=1", busy, timeout_err);
    end
    ready_wait = READY;
    do_clear();
    n_cmp++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL clear_error: terr=%b busy=%b, expected terr=0 busy=0", timeout_err, busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL clear_emptied: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_priority();
    write_vec(1, 32'h0000_1111);
    run_pass(1'b0, 1'b1, 3, 32'h0000_4444);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    model_clear();
    n_cmp++;
    if (busy !== 1'b0 || learning_recall !== LEARNING) begin
      n_err++;
      $display("FAIL clear_vs_start: busy=%b recall=%b, expected busy=0 recall=0", busy, learning_recall);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL store_cleared: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_pass();
    write_vec(0, 32'hA1);
    write_vec(0, 32'hA2);
    write_vec(0, 32'hA3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ready_wait = READY;
    @(negedge clk);
    ready_wait = WAIT;
    @(negedge clk);
    ready_wait = READY;
    @(negedge clk);
    @(negedge clk);
    ready_wait = WAIT;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || x !== 32'hA2 || c !== 32'd1) begin
      n_err++;
      $display("FAIL pre_reset: busy=%b x=%h c=%0d, expected busy=1 x=a2 c=1", busy, x, c);
    end
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if (x !== '0 || c !== '0 || learning_done !== 1'b0 || learning_recall !== LEARNING ||
        busy !== 1'b0 || timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: x=%h c=%0d done=%b recall=%b busy=%b terr=%b, expected all 0",
               x, c, learning_done, learning_recall, busy, timeout_err);
    end
    @(negedge clk);
    reset = 1'b1;
    ready_wait = READY;
    model_clear();
    hold_x = '0;
    hold_c = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || x !== '0 || c !== '0) begin
      n_err++;
      $display("FAIL start_after_reset: busy=%b x=%h c=%0d, expected busy=0 x=0 c=0", busy, x, c);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b0;
    clear      = 1'b0;
    wr_en      = 1'b0;
    wr_class   = '0;
    wr_data    = '0;
    start      = 1'b0;
    ready_wait = READY;
    hold_x     = '0;
    hold_c     = '0;
    model_clear();
    test_reset();
    test_one_class();
    test_skip_and_back_to_back();
    test_full();
    test_timeout();
    test_priority();
    test_reset_mid_pass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gam_learning_sequencer.md
# gam_learning_sequencer

Controller that sequences the GAM `Memory_Layer` through a learning pass. A host loads training patterns per class into an internal pattern store. On `start`, the block presents each stored node vector with its class number to the memory layer, paced by the layer's `ready_wait` handshake. It drives `learning_done` with the final pattern, then switches the layer to recall mode. It replaces hand-written stimulus sequencing and sits directly in front of `Memory_Layer` (`x`, `c`, `learning_done`, `learning_recall`, `ready_wait`).

## Interface
- CLASS_COUNT, 4, number of classes; classes are numbered 1..CLASS_COUNT on `c`
- NODE_COUNT, 8, maximum stored node vectors per class
- TIMEOUT, 64, maximum cycles to wait for any single handshake phase

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  one clock; reset is asynchronous and active-low
- clear  in  1  synchronous; empties the pattern store, clears `timeout_err`, returns to IDLE
- wr_en  in  1  append `wr_data` to class `wr_class` (0-based)
- wr_class  in  $clog2(CLASS_COUNT)  target class for the append
- wr_data  in  node_vector_T (32)  node vector to store
- wr_full  out  1  combinational; class `wr_class` already holds NODE_COUNT vectors
- start  in  1  begin a learning pass; accepted in IDLE or DONE only
- ready_wait  in  READY_WAIT_T  from Memory_Layer
- x  out  node_vector_T  node vector presented to Memory_Layer
- c  out  int (32)  class number of `x`, 1-based
- learning_done  out  1  high while the last pattern of the pass is presented
- learning_recall  out  LEARNING_RECALL_T  mode driven to Memory_Layer
- busy  out  1  high in LOAD, PRESENT and BUSY
- timeout_err  out  1  sticky; set on handshake timeout

## Operation
- Store: CLASS_COUNT×NODE_COUNT words plus a per-class count `cnt[k]` of width $clog2(NODE_COUNT+1).
  - Append only. `wr_en` with `wr_full`=0 writes `store[wr_class][cnt]` and increments `cnt`.
  - `wr_en` with `wr_full`=1 is ignored.
  - Writes are ignored outside IDLE and DONE.
- Order: class 0 to CLASS_COUNT-1. Within a class, node 0 to cnt-1. Classes with cnt=0 are skipped.
- FSM states:
  - IDLE, DONE: `start` with any cnt≠0 → LOAD at the first non-empty class, node 0. `start` with all cnt=0 is ignored.
  - LOAD: one cycle, registered store read → PRESENT.
  - PRESENT: `x`/`c` held stable. `ready_wait`==WAIT (layer has latched the pattern) → BUSY.
  - BUSY: `ready_wait`==READY → LOAD for the next pattern, or → DONE if the pattern just consumed was the last.
  - DONE: `learning_recall`=RECALL; `x`/`c` hold the last values.
  - ERROR: entered from PRESENT or BUSY on timeout; sets `timeout_err`. Left only via `clear` or reset.
- `learning_done`: high in LOAD/PRESENT/BUSY of the last pattern of the pass, low otherwise.
- `learning_recall`: LEARNING in every state except DONE.
- Timeout counter, $clog2(TIMEOUT+1) bits:
  - cleared on every state entry;
  - increments in PRESENT and BUSY;
  - reaching TIMEOUT → ERROR.
- Simultaneous events:
  - `clear` has priority over `start` and `wr_en`.
  - `start` and `wr_en` in the same cycle: the write lands first and is included in the pass.
- Reset mid-pass: immediate return to IDLE, store counts zeroed, no further handshakes.

## Timing
- Reset values: `x`=0, `c`=0, `learning_done`=0, `learning_recall`=LEARNING, `busy`=0, `timeout_err`=0, state IDLE, all cnt=0.
- `start` at edge n: LOAD at n+1, `x`/`c` valid at n+2 (PRESENT).
- Per pattern: minimum 3 cycles (LOAD, PRESENT, BUSY), with `ready_wait` dropping to WAIT and returning to READY one cycle each.
- BUSY→DONE: `learning_recall` becomes RECALL on the cycle after `ready_wait` returns to READY for the last pattern.
- `x`/`c` change only on LOAD→PRESENT.
- `ready_wait` is ignored in IDLE, LOAD, DONE and ERROR.

## Structure
- GAM_package already holds `node_vector_T`, `LEARNING_RECALL_T`, `READY_WAIT_T`, CLASS_COUNT and NODE_COUNT. Add the state enum `SEQ_STATE_T` (IDLE, LOAD, PRESENT, BUSY, DONE, ERROR) there.
- One sub-module, `gam_pattern_store`: store array, per-class counts, `wr_full`, registered read port addressed by (class, node).
- The FSM, pointer advance/skip logic and timeout counter stay in `gam_learning_sequencer`.

## Test plan
- Pass 1 (one class):
  - Stimulus: load class 0 with 0x0003, 0x0400, 0x070005; `start`; Memory_Layer model answers WAIT then READY.
  - Required: `x` sequence 0x0003, 0x0400, 0x070005, all with `c`=1; `learning_done` high only on 0x070005; then `learning_recall`=RECALL.
- Skip empty classes:
  - Stimulus: load class 0 and class 2 with 2 vectors each, class 1 empty.
  - Required: `c` sequence 1,1,3,3; four handshakes total.
- Full store:
  - Stimulus: write NODE_COUNT+1 vectors to class 3.
  - Required: `wr_full`=1 after the 8th write; the 9th write is not stored; the pass presents exactly 8 vectors with `c`=4.
- Timeout:
  - Stimulus: hold `ready_wait`=READY in PRESENT for 64 cycles.
  - Required: state ERROR, `timeout_err`=1, `busy`=0; `clear` returns to IDLE with `timeout_err`=0.
- Reset mid-pass:
  - Stimulus: drop `reset` during BUSY of pattern 2.
  - Required: all outputs at reset values asynchronously; a subsequent `start` with an empty store is ignored.
- Priority:
  - Stimulus: `start` and `wr_en` in the same cycle; separately, `clear` and `start` in the same cycle.
  - Required: the written vector is presented last in the pass; `clear` wins, leaving the block in IDLE with the store empty.
